// File: rtl/psum_out_acc_ctrl_if.sv
// ---------------------------------------------------------------------------
// psum_out_acc_ctrl_if
//
// Bundles the three data paths of the psum output-accumulation controller:
//   - psum SRAM read port    : sram_rd_en, sram_rd_addr (ctrl -> SRAM),
//                              sram_rd_data (SRAM -> ctrl, one cycle after strobe)
//   - accumulator port       : acc_en, acc_data_in, acc_data_in_valid (ctrl -> acc),
//                              acc_data_out, acc_data_out_valid (acc -> ctrl)
//   - output stream          : out_data, out_valid (ctrl -> writer),
//                              out_ready (writer -> ctrl)
//
// Modports:
//   master - the controller side
//   slave  - the environment side (SRAM, accumulator, output writer)
//
// Parameter:
//   ADDR_W - psum SRAM address width
// ---------------------------------------------------------------------------
interface psum_out_acc_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic                     sram_rd_en;
    logic [ADDR_W-1:0]        sram_rd_addr;
    logic signed [20:0]       sram_rd_data;

    logic                     acc_en;
    logic signed [20:0]       acc_data_in;
    logic                     acc_data_in_valid;
    logic signed [20:0]       acc_data_out;
    logic                     acc_data_out_valid;

    logic signed [20:0]       out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output sram_rd_en,
        output sram_rd_addr,
        input  sram_rd_data,
        output acc_en,
        output acc_data_in,
        output acc_data_in_valid,
        input  acc_data_out,
        input  acc_data_out_valid,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  sram_rd_en,
        input  sram_rd_addr,
        output sram_rd_data,
        input  acc_en,
        input  acc_data_in,
        input  acc_data_in_valid,
        output acc_data_out,
        output acc_data_out_valid,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/psum_out_acc_ctrl.sv
// ---------------------------------------------------------------------------
// psum_out_acc_ctrl
//
// Sequences the psum-SRAM output accumulation path. After a start pulse it
// reads the psum SRAM group by group (BATCHES*CHANNELS words per group,
// channel-major), forwards each word to the accumulator, collects the
// BATCHES per-batch results of each group into an output FIFO and presents
// them on a valid/ready stream. A group is only issued when the FIFO has room
// for all of its results, since the accumulator cannot be stalled.
//
// Ports:
//   clock, reset      - clock; synchronous active-high reset
//   start             - single-cycle start pulse (honoured only when idle)
//   base_addr         - first SRAM address, sampled on accepted start
//   num_groups        - number of groups, sampled on accepted start
//   bus (master)      - SRAM read port, accumulator port, output stream
//   busy              - high while a run is in progress
//   done              - one-cycle pulse at the end of a run
//
// Build option:
//   PSUM_RELU_EN      - when defined, negative accumulator results are
//                       stored in the FIFO as zero (ReLU); otherwise the
//                       signed result is stored unmodified.
// ---------------------------------------------------------------------------
module psum_out_acc_ctrl #(
    parameter int BATCHES    = 4,
    parameter int CHANNELS   = 3,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [7:0]           num_groups,
    psum_out_acc_ctrl_if.master  bus,
    output logic                 busy,
    output logic                 done
);

    localparam int WORDS = BATCHES * CHANNELS;
    localparam int K_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PC_W  = $clog2(BATCHES + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_W-1:0] GROUP_STRIDE = ADDR_W'(WORDS);
    // Highest fill level at which a whole group's results still fit.
    localparam logic [CNT_W-1:0]  ARM_MAX_FILL = CNT_W'(FIFO_DEPTH - BATCHES);
    localparam logic [K_W-1:0]    K_LAST       = K_W'(WORDS - 1);
    localparam logic [PC_W-1:0]   PC_LAST      = PC_W'(BATCHES - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARM   = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   group_base_q, group_base_d;   // base_addr + group_cnt*WORDS
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          num_groups_q, num_groups_d;
    logic [7:0]          group_cnt_q, group_cnt_d;
    logic [7:0]          group_cnt_inc;
    logic [K_W-1:0]      k_q, k_d;
    logic [PC_W-1:0]     push_cnt_q, push_cnt_d;
    logic                acc_valid_q, acc_valid_d;

    logic signed [20:0]  fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                push;
    logic                pop;
    logic signed [20:0]  push_data;

    // ------------------------------------------------------------------
    // FIFO push/pop qualification
    // ------------------------------------------------------------------
    // Results arriving outside WAIT do not belong to an issued group.
    assign push = (state_q == WAIT) && bus.acc_data_out_valid;
    assign pop  = (count_q != '0) && bus.out_ready;

`ifdef PSUM_RELU_EN
    assign push_data = bus.acc_data_out[20] ? 21'sd0 : bus.acc_data_out;
`else
    assign push_data = bus.acc_data_out;
`endif

    assign group_cnt_inc = group_cnt_q + 8'd1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        group_base_d = group_base_q;
        addr_d       = addr_q;
        num_groups_d = num_groups_q;
        group_cnt_d  = group_cnt_q;
        k_d          = k_q;
        push_cnt_d   = push_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    group_base_d = base_addr;
                    num_groups_d = num_groups;
                    group_cnt_d  = 8'd0;
                    state_d      = (num_groups == 8'd0) ? DONE : ARM;
                end
            end
            ARM: begin
                if (count_q <= ARM_MAX_FILL) begin
                    addr_d  = group_base_q;
                    k_d     = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                addr_d = addr_q + 1'b1;
                k_d    = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    push_cnt_d = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (push) begin
                    push_cnt_d = push_cnt_q + 1'b1;
                    if (push_cnt_q == PC_LAST) begin
                        group_cnt_d  = group_cnt_inc;
                        group_base_d = group_base_q + GROUP_STRIDE;
                        state_d      = (group_cnt_inc == num_groups_q) ? DONE : ARM;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The SRAM answers one cycle after the strobe, so the strobe delayed by
    // one cycle marks exactly the cycle in which the returned word is on
    // sram_rd_data.
    assign acc_valid_d = (state_q == ISSUE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            group_base_q <= '0;
            addr_q       <= '0;
            num_groups_q <= '0;
            group_cnt_q  <= '0;
            k_q          <= '0;
            push_cnt_q   <= '0;
            acc_valid_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            group_base_q <= group_base_d;
            addr_q       <= addr_d;
            num_groups_q <= num_groups_d;
            group_cnt_q  <= group_cnt_d;
            k_q          <= k_d;
            push_cnt_q   <= push_cnt_d;
            acc_valid_q  <= acc_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible while count_q says so.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.sram_rd_en        = (state_q == ISSUE);
    assign bus.sram_rd_addr      = addr_q;
    assign bus.acc_en            = (state_q == ARM) || (state_q == ISSUE) || (state_q == WAIT);
    assign bus.acc_data_in_valid = acc_valid_q;
    assign bus.acc_data_in       = acc_valid_q ? bus.sram_rd_data : 21'sd0;
    assign bus.out_valid         = (count_q != '0);
    assign bus.out_data          = (count_q != '0) ? fifo_mem_q[rd_ptr_q] : 21'sd0;
    assign busy                  = (state_q == ARM) || (state_q == ISSUE) || (state_q == WAIT);
    assign done                  = (state_q == DONE);

endmodule

// File: tb/tb_psum_out_acc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_psum_out_acc_ctrl
//
// Directed bench for psum_out_acc_ctrl with a 4-bit address space (16-word
// SRAM) so address wrap can be exercised. Includes a synchronous-read SRAM
// model and a channel-summing accumulator model that emits the four batch
// sums on consecutive cycles after the twelfth word of a group.
// ---------------------------------------------------------------------------
module tb_psum_out_acc_ctrl;
    localparam int AW = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [7:0]        num_groups = 8'd0;
    logic              busy;
    logic              done;

    psum_out_acc_ctrl_if #(.ADDR_W(AW)) bus ();

    psum_out_acc_ctrl #(
        .BATCHES    (4),
        .CHANNELS   (3),
        .ADDR_W     (AW),
        .FIFO_DEPTH (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_groups (num_groups),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // SRAM model: synchronous read, data valid the cycle after the strobe.
    logic signed [20:0] mem [16];
    always @(posedge clock) begin
        if (bus.sram_rd_en) bus.sram_rd_data <= mem[bus.sram_rd_addr];
    end

    // Accumulator model: words arrive channel-major (k = c*4 + b).
    int                 acc_wc = 0;
    int                 acc_emit = 4;
    logic signed [20:0] acc_sum [4];
    always @(posedge clock) begin
        if (reset) begin
            acc_wc                 <= 0;
            acc_emit               <= 4;
            bus.acc_data_out       <= '0;
            bus.acc_data_out_valid <= 1'b0;
        end else begin
            bus.acc_data_out_valid <= 1'b0;
            if (acc_emit < 4) begin
                bus.acc_data_out       <= acc_sum[acc_emit];
                bus.acc_data_out_valid <= 1'b1;
                acc_emit               <= acc_emit + 1;
            end
            if (bus.acc_data_in_valid) begin
                if (acc_wc < 4) acc_sum[acc_wc % 4] <= bus.acc_data_in;
                else            acc_sum[acc_wc % 4] <= acc_sum[acc_wc % 4] + bus.acc_data_in;
                if (acc_wc == 11) begin
                    acc_wc   <= 0;
                    acc_emit <= 0;
                end else begin
                    acc_wc <= acc_wc + 1;
                end
            end
        end
    end

    // Monitor: read addresses, popped words, done pulses.
    logic [AW-1:0]      addr_log [$];
    logic signed [20:0] pop_log [$];
    int                 rd_cnt = 0;
    int                 done_cnt = 0;
    always @(negedge clock) begin
        if (bus.sram_rd_en === 1'b1) begin
            addr_log.push_back(bus.sram_rd_addr);
            rd_cnt <= rd_cnt + 1;
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) pop_log.push_back(bus.out_data);
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int exp_v [12];
    int r0;
    int d0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_until_done(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 1);
        chk({tag, "_busy_at_done"}, 32'(busy), 0);
    endtask

    task automatic check_addrs(input string tag, input int base, input int n);
        int bad;
        bad = 0;
        chk({tag, "_addr_count"}, addr_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i >= addr_log.size() || int'(addr_log[i]) != ((base + i) % 16)) bad++;
        end
        chk({tag, "_addr_bad"}, bad, 0);
    endtask

    task automatic check_pops(input string tag, input int n);
        logic signed [31:0] obs;
        chk({tag, "_pop_count"}, pop_log.size(), n);
        for (int i = 0; i < n; i++) begin
            obs = 'x;
            if (i < pop_log.size()) obs = 32'(pop_log[i]);
            chk($sformatf("%s_pop%0d", tag, i), obs, exp_v[i]);
        end
    endtask

    task automatic clear_logs();
        addr_log.delete();
        pop_log.delete();
        r0 = rd_cnt;
        d0 = done_cnt;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 21'(i + 1);

        // ---- reset values ----
        repeat (3) tick();
        chk("rst_rd_en",     32'(bus.sram_rd_en), 0);
        chk("rst_rd_addr",   32'(bus.sram_rd_addr), 0);
        chk("rst_acc_en",    32'(bus.acc_en), 0);
        chk("rst_in_valid",  32'(bus.acc_data_in_valid), 0);
        chk("rst_in_data",   32'(bus.acc_data_in), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  32'(bus.out_data), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_done",      32'(done), 0);
        reset = 1'b0;
        tick();

        // ---- basic run ----
        clear_logs();
        bus.out_ready = 1'b1;
        base_addr = 4'd0; num_groups = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("basic_busy_t1",   32'(busy), 1);
        chk("basic_acc_en_t1", 32'(bus.acc_en), 1);
        chk("basic_rd_en_t1",  32'(bus.sram_rd_en), 0);
        tick();
        chk("basic_rd_en_t2",  32'(bus.sram_rd_en), 1);
        chk("basic_addr_t2",   32'(bus.sram_rd_addr), 0);
        tick();
        chk("basic_in_valid_t3", 32'(bus.acc_data_in_valid), 1);
        chk("basic_in_data_t3",  32'(bus.acc_data_in), 1);
        run_until_done("basic", 60);
        repeat (3) tick();
        chk("basic_acc_en_after", 32'(bus.acc_en), 0);
        chk("basic_done_pulses",  done_cnt - d0, 1);
        check_addrs("basic", 0, 12);
        exp_v = '{15, 18, 21, 24, 0, 0, 0, 0, 0, 0, 0, 0};
        check_pops("basic", 4);

        // ---- zero groups ----
        clear_logs();
        num_groups = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_done_t1", 32'(done), 1);
        tick();
        chk("zero_done_t2", 32'(done), 0);
        chk("zero_busy_t2", 32'(busy), 0);
        chk("zero_no_reads", rd_cnt - r0, 0);
        chk("zero_done_pulses", done_cnt - d0, 1);

        // ---- backpressure + ignored start ----
        clear_logs();
        bus.out_ready = 1'b0;
        base_addr = 4'd0; num_groups = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        base_addr = 4'd5; num_groups = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (60) tick();
        chk("bp_hold_reads",     rd_cnt - r0, 24);
        chk("bp_hold_busy",      32'(busy), 1);
        chk("bp_hold_rd_en",     32'(bus.sram_rd_en), 0);
        chk("bp_hold_acc_en",    32'(bus.acc_en), 1);
        chk("bp_hold_out_valid", 32'(bus.out_valid), 1);
        chk("bp_hold_head",      32'(bus.out_data), 15);
        chk("bp_hold_no_pops",   pop_log.size(), 0);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        bus.out_ready = 1'b0;
        run_until_done("bp", 60);
        chk("bp_reads", rd_cnt - r0, 36);
        bus.out_ready = 1'b1;
        repeat (12) tick();
        chk("bp_drained", 32'(bus.out_valid), 0);
        check_addrs("bp", 0, 36);
        exp_v = '{15, 18, 21, 24, 19, 22, 25, 28, 23, 26, 29, 32};
        check_pops("bp", 12);

        // ---- address wrap ----
        clear_logs();
        base_addr = 4'd10; num_groups = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done("wrap", 60);
        repeat (6) tick();
        check_addrs("wrap", 10, 12);
        exp_v = '{29, 32, 19, 22, 0, 0, 0, 0, 0, 0, 0, 0};
        check_pops("wrap", 4);

        // ---- reset during ISSUE ----
        clear_logs();
        base_addr = 4'd0; num_groups = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("mid_reads",     rd_cnt - r0, 5);
        chk("mid_rd_en",     32'(bus.sram_rd_en), 0);
        chk("mid_rd_addr",   32'(bus.sram_rd_addr), 0);
        chk("mid_acc_en",    32'(bus.acc_en), 0);
        chk("mid_in_valid",  32'(bus.acc_data_in_valid), 0);
        chk("mid_in_data",   32'(bus.acc_data_in), 0);
        chk("mid_out_valid", 32'(bus.out_valid), 0);
        chk("mid_busy",      32'(busy), 0);
        chk("mid_done",      32'(done), 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("mid_no_done", done_cnt - d0, 0);
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done("rerun", 60);
        repeat (6) tick();
        check_addrs("rerun", 0, 12);
        exp_v = '{15, 18, 21, 24, 0, 0, 0, 0, 0, 0, 0, 0};
        check_pops("rerun", 4);

        // ---- sign / ReLU ----
        clear_logs();
        mem[0] = -21'sd10; mem[4] = 21'sd2; mem[8] = 21'sd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done("sign", 60);
        repeat (6) tick();
`ifdef PSUM_RELU_EN
        exp_v = '{0, 18, 21, 24, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_v = '{-7, 18, 21, 24, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        check_pops("sign", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
